// File: rtl/vdp_arb_pkg.sv
// Shared types and constants for the VDP VRAM slot arbiter.
package vdp_arb_pkg;

  // Slot owner, registered at the end of the arbitration cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2,
    OWN_CMD  = 2'd3
  } owner_t;

  // Phase numbers within the 4-cycle access slot.
  localparam logic [1:0] PH_ARB   = 2'd0;  // requests sampled, winner chosen
  localparam logic [1:0] PH_WE0   = 2'd1;  // address/data on the bus, first write cycle
  localparam logic [1:0] PH_LATCH = 2'd2;  // read data captured at the end of this cycle
  localparam logic [1:0] PH_ACK   = 2'd3;  // owner's ACK pulse

  // VRAM address width (128 KiB).
  localparam int VRAM_AW = 17;

endpackage

// File: rtl/vdp_arb_select.sv
// Slot winner selection: display first, then round-robin between CPU and
// the command engine. The command engine is only eligible while paced on.
module vdp_arb_select
  import vdp_arb_pkg::*;
(
  input  logic   disp_req,
  input  logic   cpu_req,
  input  logic   cmd_req,
  input  logic   cmd_active,
  input  logic   last_cmd,   // 1 = previous CPU/CMD grant went to CMD
  output owner_t winner
);

  logic cmd_ok;

  assign cmd_ok = cmd_req & cmd_active;

  // Priority with round-robin tie break between CPU and CMD.
  always_comb begin
    winner = OWN_NONE;
    if (disp_req) begin
      winner = OWN_DISP;
    end else if (cpu_req && cmd_ok) begin
      winner = last_cmd ? OWN_CPU : OWN_CMD;
    end else if (cpu_req) begin
      winner = OWN_CPU;
    end else if (cmd_ok) begin
      winner = OWN_CMD;
    end
  end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Slot-based VRAM arbiter: one 8-bit access every four CLK21M cycles,
// shared between display fetch, CPU port and command engine.
module vdp_vram_arbiter
  import vdp_arb_pkg::*;
(
  input  logic               CLK21M,
  input  logic               RESET,
  input  logic               DISP_REQ,
  input  logic [VRAM_AW-1:0] DISP_ADDR,
  output logic               DISP_ACK,
  output logic [7:0]         DISP_DATA,
  input  logic               CPU_REQ,
  input  logic               CPU_WE,
  input  logic [VRAM_AW-1:0] CPU_ADDR,
  input  logic [7:0]         CPU_WDATA,
  output logic               CPU_ACK,
  output logic [7:0]         CPU_RDATA,
  input  logic               CMD_REQ,
  input  logic               CMD_WE,
  input  logic [VRAM_AW-1:0] CMD_ADDR,
  input  logic [7:0]         CMD_WDATA,
  output logic               CMD_ACK,
  output logic [7:0]         CMD_RDATA,
  input  logic               CMD_ACTIVE,
  output logic [VRAM_AW-1:0] VRAM_ADDR,
  output logic               VRAM_WE,
  output logic [7:0]         VRAM_DOUT,
  input  logic [7:0]         VRAM_DIN
);

  logic [1:0]         phase_reg;
  owner_t             owner_reg;
  owner_t             winner;
  logic               last_cmd_reg;
  logic               we_sel_reg;
  logic [VRAM_AW-1:0] vram_addr_reg;
  logic [7:0]         vram_dout_reg;
  logic               vram_we_reg;
  logic               disp_ack_reg;
  logic               cpu_ack_reg;
  logic               cmd_ack_reg;
  logic [7:0]         disp_data_reg;
  logic [7:0]         cpu_rdata_reg;
  logic [7:0]         cmd_rdata_reg;

  vdp_arb_select u_select (
    .disp_req   (DISP_REQ),
    .cpu_req    (CPU_REQ),
    .cmd_req    (CMD_REQ),
    .cmd_active (CMD_ACTIVE),
    .last_cmd   (last_cmd_reg),
    .winner     (winner)
  );

  // Free-running slot phase; reset restarts the slot at the arbitration cycle.
  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      phase_reg <= PH_ARB;
    end else begin
      phase_reg <= phase_reg + 2'd1;
    end
  end

  // Owner register, round-robin state and VRAM bus drive.
  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      owner_reg     <= OWN_NONE;
      last_cmd_reg  <= 1'b1;  // first CPU/CMD tie goes to CPU
      we_sel_reg    <= 1'b0;
      vram_addr_reg <= '0;
      vram_dout_reg <= '0;
      vram_we_reg   <= 1'b0;
    end else begin
      case (phase_reg)
        PH_ARB: begin
          owner_reg <= winner;
          case (winner)
            OWN_DISP: begin
              vram_addr_reg <= DISP_ADDR;
              we_sel_reg    <= 1'b0;
            end
            OWN_CPU: begin
              vram_addr_reg <= CPU_ADDR;
              vram_dout_reg <= CPU_WDATA;
              we_sel_reg    <= CPU_WE;
              vram_we_reg   <= CPU_WE;
              last_cmd_reg  <= 1'b0;
            end
            OWN_CMD: begin
              vram_addr_reg <= CMD_ADDR;
              vram_dout_reg <= CMD_WDATA;
              we_sel_reg    <= CMD_WE;
              vram_we_reg   <= CMD_WE;
              last_cmd_reg  <= 1'b1;
            end
            default: begin
              // Idle slot: bus address and data keep their previous values.
              we_sel_reg <= 1'b0;
            end
          endcase
        end
        PH_LATCH: begin
          // Write strobe covers phases 1 and 2 only.
          vram_we_reg <= 1'b0;
        end
        PH_ACK: begin
          owner_reg <= OWN_NONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Read data capture and one-cycle ACK pulse in the final phase.
  always_ff @(posedge CLK21M) begin
    if (RESET) begin
      disp_ack_reg  <= 1'b0;
      cpu_ack_reg   <= 1'b0;
      cmd_ack_reg   <= 1'b0;
      disp_data_reg <= '0;
      cpu_rdata_reg <= '0;
      cmd_rdata_reg <= '0;
    end else begin
      disp_ack_reg <= 1'b0;
      cpu_ack_reg  <= 1'b0;
      cmd_ack_reg  <= 1'b0;
      if (phase_reg == PH_LATCH) begin
        case (owner_reg)
          OWN_DISP: begin
            disp_ack_reg  <= 1'b1;
            disp_data_reg <= VRAM_DIN;
          end
          OWN_CPU: begin
            cpu_ack_reg <= 1'b1;
            if (!we_sel_reg) cpu_rdata_reg <= VRAM_DIN;
          end
          OWN_CMD: begin
            cmd_ack_reg <= 1'b1;
            if (!we_sel_reg) cmd_rdata_reg <= VRAM_DIN;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign VRAM_ADDR = vram_addr_reg;
  assign VRAM_DOUT = vram_dout_reg;
  assign VRAM_WE   = vram_we_reg;
  assign DISP_ACK  = disp_ack_reg;
  assign CPU_ACK   = cpu_ack_reg;
  assign CMD_ACK   = cmd_ack_reg;
  assign DISP_DATA = disp_data_reg;
  assign CPU_RDATA = cpu_rdata_reg;
  assign CMD_RDATA = cmd_rdata_reg;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Directed bench for the VDP VRAM slot arbiter.
module tb_vdp_vram_arbiter;

  logic        CLK21M = 1'b0;
  logic        RESET = 1'b1;
  logic        DISP_REQ = 1'b0;
  logic [16:0] DISP_ADDR = '0;
  logic        DISP_ACK;
  logic [7:0]  DISP_DATA;
  logic        CPU_REQ = 1'b0;
  logic        CPU_WE = 1'b0;
  logic [16:0] CPU_ADDR = '0;
  logic [7:0]  CPU_WDATA = '0;
  logic        CPU_ACK;
  logic [7:0]  CPU_RDATA;
  logic        CMD_REQ = 1'b0;
  logic        CMD_WE = 1'b0;
  logic [16:0] CMD_ADDR = '0;
  logic [7:0]  CMD_WDATA = '0;
  logic        CMD_ACK;
  logic [7:0]  CMD_RDATA;
  logic        CMD_ACTIVE = 1'b0;
  logic [16:0] VRAM_ADDR;
  logic        VRAM_WE;
  logic [7:0]  VRAM_DOUT;
  logic [7:0]  VRAM_DIN = '0;

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  ph = 2'd0;

  always #5 CLK21M = ~CLK21M;

  vdp_vram_arbiter dut (
    .CLK21M     (CLK21M),
    .RESET      (RESET),
    .DISP_REQ   (DISP_REQ),
    .DISP_ADDR  (DISP_ADDR),
    .DISP_ACK   (DISP_ACK),
    .DISP_DATA  (DISP_DATA),
    .CPU_REQ    (CPU_REQ),
    .CPU_WE     (CPU_WE),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_WDATA  (CPU_WDATA),
    .CPU_ACK    (CPU_ACK),
    .CPU_RDATA  (CPU_RDATA),
    .CMD_REQ    (CMD_REQ),
    .CMD_WE     (CMD_WE),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_WDATA  (CMD_WDATA),
    .CMD_ACK    (CMD_ACK),
    .CMD_RDATA  (CMD_RDATA),
    .CMD_ACTIVE (CMD_ACTIVE),
    .VRAM_ADDR  (VRAM_ADDR),
    .VRAM_WE    (VRAM_WE),
    .VRAM_DOUT  (VRAM_DOUT),
    .VRAM_DIN   (VRAM_DIN)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One cycle; outputs are sampled on the falling edge.
  task automatic step();
    @(negedge CLK21M);
    ph = ph + 2'd1;
  endtask

  task automatic to_ph(input logic [1:0] t);
    do step(); while (ph != t);
  endtask

  function automatic logic [31:0] acks();
    return 32'({DISP_ACK, CPU_ACK, CMD_ACK});
  endfunction

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge CLK21M);
    chk("rst_addr", 32'(VRAM_ADDR), 32'h0);
    chk("rst_dout", 32'(VRAM_DOUT), 32'h0);
    chk("rst_we", 32'(VRAM_WE), 32'h0);
    chk("rst_acks", acks(), 32'h0);
    chk("rst_data", 32'({DISP_DATA, CPU_RDATA, CMD_RDATA}), 32'h0);
    RESET = 1'b0;
    ph = 2'd0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("idle_we", 32'(VRAM_WE), 32'h0);
      chk("idle_acks", acks(), 32'h0);
    end
    $display("idle: 16 cycles without grant");

    // ---------------- CPU read ----------------
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'h01234;
    to_ph(2'd1);
    chk("cpurd_addr1", 32'(VRAM_ADDR), 32'h01234);
    chk("cpurd_we1", 32'(VRAM_WE), 32'h0);
    VRAM_DIN = 8'hA5;
    to_ph(2'd2);
    chk("cpurd_addr2", 32'(VRAM_ADDR), 32'h01234);
    chk("cpurd_ack2", acks(), 32'h0);
    to_ph(2'd3);
    chk("cpurd_addr3", 32'(VRAM_ADDR), 32'h01234);
    chk("cpurd_ack3", acks(), 32'h2);
    chk("cpurd_data", 32'(CPU_RDATA), 32'hA5);
    CPU_REQ = 1'b0; VRAM_DIN = 8'h00;
    to_ph(2'd0);
    chk("cpurd_ack0", acks(), 32'h0);
    chk("cpurd_hold", 32'(CPU_RDATA), 32'hA5);
    $display("cpu read: addr=01234 data=%h", CPU_RDATA);

    // ---------------- CPU/CMD write contention ----------------
    // Last grant went to CPU, so the first tie goes to CMD.
    to_ph(2'd3);
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 17'h00100; CPU_WDATA = 8'h11;
    CMD_REQ = 1'b1; CMD_WE = 1'b1; CMD_ADDR = 17'h00200; CMD_WDATA = 8'h22;
    CMD_ACTIVE = 1'b1;
    for (int s = 0; s < 4; s++) begin
      logic is_cmd;
      is_cmd = (s % 2 == 0);
      to_ph(2'd1);
      chk("rr_addr", 32'(VRAM_ADDR), is_cmd ? 32'h00200 : 32'h00100);
      chk("rr_dout", 32'(VRAM_DOUT), is_cmd ? 32'h22 : 32'h11);
      chk("rr_we1", 32'(VRAM_WE), 32'h1);
      to_ph(2'd2);
      chk("rr_we2", 32'(VRAM_WE), 32'h1);
      to_ph(2'd3);
      chk("rr_we3", 32'(VRAM_WE), 32'h0);
      chk("rr_ack", acks(), is_cmd ? 32'h1 : 32'h2);
      $display("contention slot %0d: owner=%s", s, is_cmd ? "CMD" : "CPU");
    end
    CPU_REQ = 1'b0; CMD_REQ = 1'b0;
    chk("rr_cpu_rdata", 32'(CPU_RDATA), 32'hA5);
    chk("rr_cmd_rdata", 32'(CMD_RDATA), 32'h00);

    // ---------------- DISP priority over CPU and CMD ----------------
    // LAST is CPU; display slots must not change it, so CMD goes next.
    DISP_REQ = 1'b1; DISP_ADDR = 17'h0ABCD;
    CPU_REQ = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 17'h00010;
    CMD_REQ = 1'b1; CMD_WE = 1'b1; CMD_ADDR = 17'h00300; CMD_WDATA = 8'h33;
    VRAM_DIN = 8'h5A;
    for (int s = 0; s < 3; s++) begin
      to_ph(2'd1);
      chk("disp_addr", 32'(VRAM_ADDR), 32'h0ABCD);
      chk("disp_we", 32'(VRAM_WE), 32'h0);
      to_ph(2'd3);
      chk("disp_ack", acks(), 32'h4);
      chk("disp_data", 32'(DISP_DATA), 32'h5A);
      $display("display slot %0d: addr=0abcd", s);
    end
    DISP_REQ = 1'b0;
    to_ph(2'd1);
    chk("after_disp_cmd_addr", 32'(VRAM_ADDR), 32'h00300);
    chk("after_disp_cmd_we", 32'(VRAM_WE), 32'h1);
    to_ph(2'd3);
    chk("after_disp_cmd_ack", acks(), 32'h1);
    CMD_REQ = 1'b0;
    to_ph(2'd1);
    chk("after_disp_cpu_addr", 32'(VRAM_ADDR), 32'h00010);
    to_ph(2'd3);
    chk("after_disp_cpu_ack", acks(), 32'h2);
    chk("after_disp_cpu_data", 32'(CPU_RDATA), 32'h5A);
    CPU_REQ = 1'b0;
    $display("after display: CMD then CPU served");

    // ---------------- CMD request without pacing ----------------
    CMD_REQ = 1'b1; CMD_WE = 1'b0; CMD_ADDR = 17'h00400; CMD_ACTIVE = 1'b0;
    for (int s = 0; s < 3; s++) begin
      to_ph(2'd1);
      chk("paced_addr_hold", 32'(VRAM_ADDR), 32'h00010);
      chk("paced_we", 32'(VRAM_WE), 32'h0);
      to_ph(2'd3);
      chk("paced_ack", acks(), 32'h0);
      $display("paced slot %0d: idle", s);
    end
    CMD_ACTIVE = 1'b1; VRAM_DIN = 8'hC3;
    to_ph(2'd1);
    chk("paced_go_addr", 32'(VRAM_ADDR), 32'h00400);
    to_ph(2'd3);
    chk("paced_go_ack", acks(), 32'h1);
    chk("paced_go_data", 32'(CMD_RDATA), 32'hC3);
    CMD_REQ = 1'b0;
    $display("cmd read after pacing: data=%h", CMD_RDATA);

    // ---------------- reset mid-slot ----------------
    CPU_REQ = 1'b1; CPU_WE = 1'b1; CPU_ADDR = 17'h00500; CPU_WDATA = 8'h55;
    to_ph(2'd1);
    chk("mid_we_before", 32'(VRAM_WE), 32'h1);
    RESET = 1'b1;
    step();
    ph = 2'd0;
    chk("mid_we_after", 32'(VRAM_WE), 32'h0);
    chk("mid_addr_after", 32'(VRAM_ADDR), 32'h0);
    chk("mid_acks_after", acks(), 32'h0);
    RESET = 1'b0;
    to_ph(2'd1);
    chk("mid_regrant_we", 32'(VRAM_WE), 32'h1);
    chk("mid_regrant_addr", 32'(VRAM_ADDR), 32'h00500);
    chk("mid_regrant_dout", 32'(VRAM_DOUT), 32'h55);
    to_ph(2'd3);
    chk("mid_regrant_ack", acks(), 32'h2);
    CPU_REQ = 1'b0;
    $display("reset mid-slot: cpu write re-granted");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
